// File: rtl/fixed_pkg.sv
// Q16.16 fixed-point type shared by the raster datapath.
// Integer extraction keeps one spare bit so vertex differences never overflow.
package fixed_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] fixed_t;

    function automatic logic signed [16:0] fx_int(input fixed_t v);
        return 17'(v >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/raster_pkg.sv
// Triangle storage types, depth sentinel and scheduler state encoding.
package raster_pkg;
    import fixed_pkg::*;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        logic [11:0]        color;
    } vertex_t;

    typedef struct packed {
        vertex_t [2:0] v;
    } tri_t;

    localparam logic signed [31:0] Z_FAR = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } sched_state_t;

endpackage

// File: rtl/triangle_pixel_eval.sv
// Coverage, perspective-free z and colour of one triangle at one pixel.
// Purely combinational: zero latency.
// No handshake; the caller holds inputs stable for as long as it needs the result.
module triangle_pixel_eval
    import fixed_pkg::*;
    import raster_pkg::*;
(
    input  tri_t   tri_in,
    input  fixed_t px,
    input  fixed_t py,
    output logic   p_inside,
    output fixed_t pz,
    output color_t p_color
);

    typedef logic signed [47:0] wide_t;
    typedef logic signed [81:0] acc_t;

    function automatic wide_t edge_fn(input logic signed [16:0] ax, ay, bx, by, cx, cy);
        return (wide_t'(bx) - wide_t'(ax)) * (wide_t'(cy) - wide_t'(ay))
             - (wide_t'(by) - wide_t'(ay)) * (wide_t'(cx) - wide_t'(ax));
    endfunction

    logic signed [16:0] xi [3];
    logic signed [16:0] yi [3];
    logic signed [16:0] sx, sy;
    wide_t              w  [3];
    wide_t              wn [3];
    wide_t              area, denom, denom_safe;
    acc_t               num, quot;
    logic               flip;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            xi[i] = fx_int(tri_in.v[i].x);
            yi[i] = fx_int(tri_in.v[i].y);
        end
        sx = fx_int(px);
        sy = fx_int(py);

        // w[i] is the weight of vertex i: sub-area opposite that vertex
        w[0] = edge_fn(xi[1], yi[1], xi[2], yi[2], sx, sy);
        w[1] = edge_fn(xi[2], yi[2], xi[0], yi[0], sx, sy);
        w[2] = edge_fn(xi[0], yi[0], xi[1], yi[1], sx, sy);
        area = w[0] + w[1] + w[2];

        // Fold clockwise triangles onto counter-clockwise so one sign test suffices
        flip  = area < 0;
        denom = flip ? -area : area;
        for (int i = 0; i < 3; i++) begin
            wn[i] = flip ? -w[i] : w[i];
        end
        denom_safe = (denom == 0) ? wide_t'(1) : denom;

        p_inside = (denom != 0) && (wn[0] >= 0) && (wn[1] >= 0) && (wn[2] >= 0);

        num = '0;
        for (int i = 0; i < 3; i++) begin
            num = num + acc_t'(wn[i]) * acc_t'($signed(tri_in.v[i].z));
        end
        quot = num / acc_t'(denom_safe);
        pz   = p_inside ? fixed_t'(quot) : Z_FAR;

        // Colour of the dominant vertex; ties fall to the lower vertex
        p_color = tri_in.v[0].color;
        if ((wn[1] > wn[0]) && (wn[1] >= wn[2])) begin
            p_color = tri_in.v[1].color;
        end else if ((wn[2] > wn[0]) && (wn[2] > wn[1])) begin
            p_color = tri_in.v[2].color;
        end
    end

endmodule

// File: rtl/tri_pixel_scheduler.sv
// Nearest-z compositing of up to MAX_TRIS stored triangles through one shared evaluator.
// Latency: n+1 cycles from pixel accept to out_valid (1 when no slots active).
// Backpressure: result held in DONE until out_ready; pix_ready is low outside IDLE.
module tri_pixel_scheduler
    import raster_pkg::*;
#(
    parameter int MAX_TRIS = 8,
    parameter int CORDW    = 10,
    parameter int IDXW     = $clog2(MAX_TRIS)
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              tri_wr_en,
    input  logic [IDXW-1:0]   tri_wr_idx,
    input  tri_t              tri_wr_data,
    input  logic [IDXW:0]     tri_count,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [CORDW-1:0]  pix_x,
    input  logic [CORDW-1:0]  pix_y,
    input  logic [11:0]       bg_color,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_color,
    output logic              out_hit,
    output logic [31:0]       out_z
);

    localparam logic [IDXW:0] N_MAX = (IDXW+1)'(MAX_TRIS);

    tri_t               tri_tab [MAX_TRIS];
    sched_state_t       state;
    logic [IDXW-1:0]    idx;
    logic [IDXW:0]      n;
    logic [IDXW:0]      n_clamp;
    logic signed [31:0] px, py;
    logic signed [31:0] best_z;
    logic               hit;
    color_t             color;

    tri_t               cur_tri;
    logic               p_inside;
    logic signed [31:0] pz;
    color_t             p_color;
    logic               last_slot;

    // Table has no reset; the writer owns its contents and frame coherence
    always_ff @(posedge clk_pix) begin
        if (tri_wr_en) begin
            tri_tab[tri_wr_idx] <= tri_wr_data;
        end
    end

    assign cur_tri   = tri_tab[idx];
    assign n_clamp   = (tri_count > N_MAX) ? N_MAX : tri_count;
    assign last_slot = ({1'b0, idx} == (n - 1'b1));

    triangle_pixel_eval u_eval (
        .tri_in   (cur_tri),
        .px       (px),
        .py       (py),
        .p_inside (p_inside),
        .pz       (pz),
        .p_color  (p_color)
    );

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state     <= IDLE;
            pix_ready <= 1'b0;
            out_valid <= 1'b0;
            idx       <= '0;
            n         <= '0;
            px        <= '0;
            py        <= '0;
            best_z    <= '0;
            hit       <= 1'b0;
            color     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pix_ready <= 1'b1;
                    if (pix_valid && pix_ready) begin
                        pix_ready <= 1'b0;
                        px        <= $signed({{(16-CORDW){1'b0}}, pix_x, 16'h0000});
                        py        <= $signed({{(16-CORDW){1'b0}}, pix_y, 16'h0000});
                        n         <= n_clamp;
                        idx       <= '0;
                        best_z    <= Z_FAR;
                        hit       <= 1'b0;
                        color     <= bg_color;
                        if (n_clamp == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    // Strict compare: on equal depth the earlier (lower) slot stays
                    if (p_inside && (pz < best_z)) begin
                        best_z <= pz;
                        color  <= p_color;
                        hit    <= 1'b1;
                    end
                    if (last_slot) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pix_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_color = color;
    assign out_hit   = hit;
    assign out_z     = best_z;

endmodule

// File: tb/tb_tri_pixel_scheduler.sv
// Directed bench for tri_pixel_scheduler with a flat-triangle reference model and per-cycle output compare.
module tb_tri_pixel_scheduler;
    import raster_pkg::*;

    localparam int MAX_TRIS = 8;
    localparam int CORDW    = 10;
    localparam int IDXW     = 3;

    logic              clk_pix = 1'b0;
    logic              rst_pix = 1'b1;
    logic              tri_wr_en = 1'b0;
    logic [IDXW-1:0]   tri_wr_idx = '0;
    tri_t              tri_wr_data = '0;
    logic [IDXW:0]     tri_count = '0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [CORDW-1:0]  pix_x = '0;
    logic [CORDW-1:0]  pix_y = '0;
    logic [11:0]       bg_color = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [11:0]       out_color;
    logic              out_hit;
    logic [31:0]       out_z;

    tri_pixel_scheduler #(.MAX_TRIS(MAX_TRIS), .CORDW(CORDW), .IDXW(IDXW)) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .tri_wr_en   (tri_wr_en),
        .tri_wr_idx  (tri_wr_idx),
        .tri_wr_data (tri_wr_data),
        .tri_count   (tri_count),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_color    (bg_color),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_color   (out_color),
        .out_hit     (out_hit),
        .out_z       (out_z)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [11:0] color;
        logic        hit;
        logic [31:0] z;
        int          acc_cyc;
        int          lat;
        bit          seen;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_results = 0;
    tri_t tab [MAX_TRIS];
    exp_t q [$];
    int   res_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    // Point coverage by sign of the three sub-areas relative to the whole triangle
    function automatic bit covers(input tri_t t, input int x, input int y);
        longint ax, ay, bx, by, cx, cy, c0, c1, c2, s;
        ax = longint'(t.v[0].x >>> 16);
        ay = longint'(t.v[0].y >>> 16);
        bx = longint'(t.v[1].x >>> 16);
        by = longint'(t.v[1].y >>> 16);
        cx = longint'(t.v[2].x >>> 16);
        cy = longint'(t.v[2].y >>> 16);
        c0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
        c1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
        c2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
        s  = c0 + c1 + c2;
        if (s > 0) return (c0 >= 0) && (c1 >= 0) && (c2 >= 0);
        if (s < 0) return (c0 <= 0) && (c1 <= 0) && (c2 <= 0);
        return 1'b0;
    endfunction

    // Bench only loads flat triangles, so depth and colour are those of vertex 0
    function automatic exp_t model(input int x, input int y, input int cnt, input logic [11:0] bg, input int acc);
        exp_t e;
        int   n;
        int   best;
        n      = (cnt > MAX_TRIS) ? MAX_TRIS : cnt;
        best   = 32'h7FFF_FFFF;
        e.color = bg;
        e.hit   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (covers(tab[i], x, y) && (int'(tab[i].v[0].z) < best)) begin
                best    = int'(tab[i].v[0].z);
                e.color = tab[i].v[0].color;
                e.hit   = 1'b1;
            end
        end
        e.z       = best;
        e.acc_cyc = acc;
        e.lat     = (n == 0) ? 1 : n + 1;
        e.seen    = 1'b0;
        return e;
    endfunction

    function automatic vertex_t mkv(input int x, input int y, input int z, input logic [11:0] c);
        vertex_t v;
        v.x     = x <<< 16;
        v.y     = y <<< 16;
        v.z     = z <<< 16;
        v.color = c;
        return v;
    endfunction

    // Compare process: outputs checked every cycle they are meaningful
    initial begin
        bit prev_rst;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk_pix);
            cyc++;
            if (prev_rst) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_pix_ready", 32'(pix_ready), 32'd0);
                check("rst_out_color", 32'(out_color), 32'd0);
                check("rst_out_hit",   32'(out_hit),   32'd0);
                check("rst_out_z",     out_z,          32'd0);
            end
            if (rst_pix) begin
                q.delete();
            end else begin
                if (out_valid) begin
                    check("pix_ready_in_done", 32'(pix_ready), 32'd0);
                    if (q.size() == 0) begin
                        fail_now("stale_result: out_valid with no pending pixel");
                    end else begin
                        if (!q[0].seen) begin
                            check("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                            q[0].seen = 1'b1;
                        end
                        check("out_color", 32'(out_color), 32'(q[0].color));
                        check("out_hit",   32'(out_hit),   32'(q[0].hit));
                        check("out_z",     out_z,          q[0].z);
                        if (out_ready) begin
                            void'(q.pop_front());
                            n_results++;
                            res_cyc.push_back(cyc);
                        end
                    end
                end
                if (pix_valid && pix_ready) begin
                    q.push_back(model(int'(pix_x), int'(pix_y), int'(tri_count), bg_color, cyc));
                end
            end
            prev_rst = rst_pix;
        end
    end

    task automatic wr_tri(input int slot, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int z, input logic [11:0] c);
        tri_t t;
        t.v[0] = mkv(x0, y0, z, c);
        t.v[1] = mkv(x1, y1, z, c);
        t.v[2] = mkv(x2, y2, z, c);
        @(posedge clk_pix); #1;
        tri_wr_en   = 1'b1;
        tri_wr_idx  = 3'(slot);
        tri_wr_data = t;
        @(posedge clk_pix); #1;
        tri_wr_en = 1'b0;
        tab[slot] = t;
    endtask

    task automatic start_pixel(input int x, input int y, input int cnt, output int acc);
        @(posedge clk_pix); #1;
        tri_count = 4'(cnt);
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_pix); #1;
            if (pix_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail_now("accept_timeout: pix_ready never rose, required 1");
        @(posedge clk_pix); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_valid(output int got);
        got = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_pix); #1;
            if (out_valid) begin
                got = cyc;
                break;
            end
        end
        if (got < 0) fail_now("result_timeout: out_valid never rose, required 1");
    endtask

    task automatic run_pixel(input int x, input int y, input int cnt, input logic [11:0] ec,
                             input logic eh, input logic [31:0] ez, input int el);
        int acc, got;
        start_pixel(x, y, cnt, acc);
        wait_valid(got);
        check("lit_latency", 32'(got - acc), 32'(el));
        check("lit_color",   32'(out_color), 32'(ec));
        check("lit_hit",     32'(out_hit),   32'(eh));
        check("lit_z",       out_z,          ez);
        @(posedge clk_pix); #1;
    endtask

    initial begin
        int acc, got, r0, s0, saw;
        bit ok;
        int xs [3];
        int ys [3];
        xs = '{10, 200, 400};
        ys = '{10, 200, 400};

        repeat (3) @(posedge clk_pix);
        #1 rst_pix = 1'b0;
        @(posedge clk_pix); #1;
        check("ready_after_reset", 32'(pix_ready), 32'd1);

        bg_color = 12'h008;
        // Basic hit, depth, tie, miss, empty
        wr_tri(0, 0, 0, 100, 0, 0, 100, 10, 12'hF00);
        run_pixel(10, 10, 1, 12'hF00, 1'b1, 32'h000A_0000, 2);
        wr_tri(1, 0, 0, 100, 0, 0, 100, 5, 12'h0F0);
        run_pixel(10, 10, 2, 12'h0F0, 1'b1, 32'h0005_0000, 3);
        wr_tri(1, 0, 0, 100, 0, 0, 100, 10, 12'h0F0);
        run_pixel(10, 10, 2, 12'hF00, 1'b1, 32'h000A_0000, 3);
        run_pixel(200, 200, 2, 12'h008, 1'b0, 32'h7FFF_FFFF, 3);
        run_pixel(10, 10, 0, 12'h008, 1'b0, 32'h7FFF_FFFF, 1);

        // Backpressure: result held, a stray request is ignored, exactly one delivery
        out_ready = 1'b0;
        start_pixel(10, 10, 1, acc);
        wait_valid(got);
        check("bp_latency", 32'(got - acc), 32'd2);
        r0 = n_results;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_pix); #1;
            pix_valid = (i == 1);
        end
        pix_valid = 1'b0;
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_color_held", 32'(out_color), 32'hF00);
        check("bp_no_delivery", 32'(n_results), 32'(r0));
        out_ready = 1'b1;
        repeat (4) @(posedge clk_pix);
        #1;
        check("bp_one_delivery", 32'(n_results), 32'(r0 + 1));
        check("bp_pulse_dropped", 32'(q.size()), 32'd0);

        // Fill the rest of the table, then clamp tri_count=15 to 8 slots
        wr_tri(2, 150, 150, 300, 150, 150, 300, 20, 12'h00F);
        for (int s = 3; s < 7; s++) begin
            wr_tri(s, 600, 600, 610, 600, 600, 610, 1, 12'h555);
        end
        wr_tri(7, 0, 0, 100, 0, 0, 100, 3, 12'h0FF);
        run_pixel(10, 10, 15, 12'h0FF, 1'b1, 32'h0003_0000, 9);
        run_pixel(200, 200, 15, 12'h00F, 1'b1, 32'h0014_0000, 9);

        // Streaming: pix_valid held high, one result every n+2 cycles
        s0 = res_cyc.size();
        @(posedge clk_pix); #1;
        tri_count = 4'd15;
        pix_valid = 1'b1;
        for (int p = 0; p < 3; p++) begin
            pix_x = 10'(xs[p]);
            pix_y = 10'(ys[p]);
            ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk_pix); #1;
                if (pix_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("stream_accept_timeout: pix_ready never rose, required 1");
            @(posedge clk_pix); #1;
        end
        pix_valid = 1'b0;
        for (int k = 0; k < 60 && res_cyc.size() < s0 + 3; k++) begin
            @(negedge clk_pix); #1;
        end
        check("stream_count", 32'(res_cyc.size() - s0), 32'd3);
        if (res_cyc.size() >= s0 + 3) begin
            check("stream_period_0", 32'(res_cyc[s0+1] - res_cyc[s0]), 32'd10);
            check("stream_period_1", 32'(res_cyc[s0+2] - res_cyc[s0+1]), 32'd10);
        end

        // Reset mid-EVAL discards the pixel
        start_pixel(10, 10, 15, acc);
        repeat (2) @(posedge clk_pix);
        #1 rst_pix = 1'b1;
        @(negedge clk_pix); #1;
        @(negedge clk_pix); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pix_ready", 32'(pix_ready), 32'd0);
        @(posedge clk_pix); #1;
        rst_pix = 1'b0;
        @(negedge clk_pix); #1;
        @(negedge clk_pix); #1;
        check("midrst_ready_after", 32'(pix_ready), 32'd1);
        saw = 0;
        repeat (15) begin
            @(negedge clk_pix); #1;
            if (out_valid) saw++;
        end
        check("midrst_no_stale", 32'(saw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
